dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_sequencer_pkg.sv | 22 ++
 rtl/dispense_sequencer_timer.sv | 34 +++
 rtl/dispense_sequencer.sv | 173 +++++++++++++++++
 tb/tb_dispense_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dispense_sequencer_pkg.sv
// Shared types and default constants for the ingredient dispense sequencer.
package dispense_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POUR   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_CH        = 8;
  localparam int unsigned DEF_NUM_RECIPES   = 32;
  localparam int unsigned DEF_RATIO_W       = 7;
  localparam int unsigned DEF_UNIT_CYCLES   = 100000000;
  localparam int unsigned DEF_SWITCH_CYCLES = 260000000;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispense_sequencer_timer.sv
// Loadable down-counter; expire_o is decoded at count==1 so a load of N
// gives exactly N cycles in the owning state.
module dispense_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/dispense_sequencer.sv
// Recipe-driven valve/carousel sequencer: pours each channel for ratio*UNIT_CYCLES,
// advancing the carousel for SWITCH_CYCLES between channels.
module dispense_sequencer
  import dispense_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned NUM_RECIPES   = DEF_NUM_RECIPES,
  parameter int unsigned RATIO_W       = DEF_RATIO_W,
  parameter int unsigned UNIT_CYCLES   = DEF_UNIT_CYCLES,
  parameter int unsigned SWITCH_CYCLES = DEF_SWITCH_CYCLES,
  localparam int unsigned RID_W        = idx_w(NUM_RECIPES),
  localparam int unsigned CH_W         = idx_w(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  // start is a one-cycle request, accepted only in IDLE; no ready is returned,
  // busy/done report progress and requests outside IDLE are dropped.
  input  logic               start,
  input  logic [RID_W-1:0]   recipe_id,
  input  logic               abort,
  input  logic               wr_en,
  input  logic [RID_W-1:0]   wr_recipe,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [RATIO_W-1:0] wr_ratio,
  output logic [NUM_CH-1:0]  valve_open,
  output logic               motor_en,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [RID_W-1:0]   cur_recipe,
  output state_t             state_dbg
);

  localparam longint unsigned POUR_MAX = ((64'd1 << RATIO_W) - 64'd1) * 64'(UNIT_CYCLES);
  localparam int unsigned POUR_W  = $clog2(POUR_MAX + 64'd1);
  localparam int unsigned SW_W    = $clog2(64'(SWITCH_CYCLES) + 64'd1);
  localparam int unsigned TMR_W   = (POUR_W > SW_W) ? POUR_W : SW_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] SW_LOAD = TMR_W'(SWITCH_CYCLES);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [RID_W-1:0]    rec_q, rec_d;
  logic [NUM_CH-1:0]   valve_q, valve_d;
  logic                motor_q, aborted_q, aborted_d;
  logic                enter_ch, tmr_load, tmr_expire, busy_w;
  logic [TMR_W-1:0]    tmr_val;
  logic [RATIO_W-1:0]  tbl_q [NUM_RECIPES][NUM_CH];
  logic [RID_W-1:0]    rd_rec;
  logic [CH_W-1:0]     rd_ch;
  logic [RATIO_W-1:0]  rd_ratio;

  assign busy_w = (state_q == ST_POUR) || (state_q == ST_SWITCH);

  // Look-ahead read: the channel about to be entered (ch 0 of recipe_id from IDLE).
  always_comb begin
    rd_rec   = (state_q == ST_IDLE) ? recipe_id : rec_q;
    rd_ch    = (state_q == ST_IDLE) ? '0 : ch_q + CH_W'(1);
    rd_ratio = '0;
    if (({1'b0, rd_rec} < (RID_W+1)'(NUM_RECIPES)) && ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH))) begin
      rd_ratio = tbl_q[rd_rec][rd_ch];
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rec_d     = rec_q;
    aborted_d = 1'b0;
    enter_ch  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rec_d    = recipe_id;
          ch_d     = '0;
          enter_ch = 1'b1;
        end
      end
      ST_POUR: begin
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
        end else if (tmr_expire) begin
          tmr_load = 1'b1;
          if (ch_q == LAST_CH) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SWITCH;
            tmr_val = SW_LOAD;
          end
        end
      end
      ST_SWITCH: begin
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
        end else if (tmr_expire) begin
          ch_d     = ch_q + CH_W'(1);
          enter_ch = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Zero-ratio channels skip POUR entirely and go straight to the next advance.
    if (enter_ch) begin
      tmr_load = 1'b1;
      if (rd_ratio != '0) begin
        state_d = ST_POUR;
        tmr_val = TMR_W'(rd_ratio) * TMR_W'(UNIT_CYCLES);
      end else if (rd_ch == LAST_CH) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_SWITCH;
        tmr_val = SW_LOAD;
      end
    end
    valve_d = (state_d == ST_POUR) ? (NUM_CH'(1) << ch_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      rec_q     <= '0;
      valve_q   <= '0;
      motor_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rec_q     <= rec_d;
      valve_q   <= valve_d;
      motor_q   <= (state_d == ST_SWITCH);
      aborted_q <= aborted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_RECIPES); r++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          tbl_q[r][c] <= '0;
        end
      end
    end else if (wr_en && !busy_w &&
                 ({1'b0, wr_recipe} < (RID_W+1)'(NUM_RECIPES)) &&
                 ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH))) begin
      tbl_q[wr_recipe][wr_ch] <= wr_ratio;
    end
  end

  dispense_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  assign valve_open = valve_q;
  assign motor_en   = motor_q;
  assign busy       = busy_w;
  assign done       = (state_q == ST_DONE);
  assign aborted    = aborted_q;
  assign cur_recipe = rec_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: per-cycle output traces against hand-built expectations.
module tb_dispense_sequencer;
  import dispense_sequencer_pkg::*;

  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned NUM_RECIPES   = 32;
  localparam int unsigned RATIO_W       = 7;
  localparam int unsigned UNIT_CYCLES   = 3;
  localparam int unsigned SWITCH_CYCLES = 2;
  localparam int RID_W = 5;
  localparam int CH_W  = 2;
  localparam int W     = 8;

  // Packed observation: {busy, done, aborted, motor_en, valve_open[3:0]}
  localparam logic [W-1:0] V0 = 8'h81, V1 = 8'h82, V2 = 8'h84, V3 = 8'h88;
  localparam logic [W-1:0] MT = 8'h90, DN = 8'h40, DA = 8'h60, ID = 8'h00;

  localparam int P_NONE = 0, P_START = 1, P_ABORT = 2, P_WRITE = 3, P_RST = 4;

  logic clk = 1'b0;
  logic rst, start, abort, wr_en;
  logic [RID_W-1:0]   recipe_id, wr_recipe, cur_recipe;
  logic [CH_W-1:0]    wr_ch;
  logic [RATIO_W-1:0] wr_ratio;
  logic [NUM_CH-1:0]  valve_open;
  logic motor_en, busy, done, aborted;
  state_t state_dbg;
  logic [W-1:0] obs_vec;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int bc;

  dispense_sequencer #(
    .NUM_CH(NUM_CH), .NUM_RECIPES(NUM_RECIPES), .RATIO_W(RATIO_W),
    .UNIT_CYCLES(UNIT_CYCLES), .SWITCH_CYCLES(SWITCH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .recipe_id(recipe_id), .abort(abort),
    .wr_en(wr_en), .wr_recipe(wr_recipe), .wr_ch(wr_ch), .wr_ratio(wr_ratio),
    .valve_open(valve_open), .motor_en(motor_en), .busy(busy), .done(done),
    .aborted(aborted), .cur_recipe(cur_recipe), .state_dbg(state_dbg)
  );

  assign obs_vec = {busy, done, aborted, motor_en, valve_open};

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tbl_wr(input int rec, input int ch, input int ratio);
    wr_en = 1'b1; wr_recipe = RID_W'(rec); wr_ch = CH_W'(ch); wr_ratio = RATIO_W'(ratio);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_pour(input int id);
    start = 1'b1; recipe_id = RID_W'(id);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_poke(input int kind);
    case (kind)
      P_START: begin start = 1'b1; recipe_id = RID_W'(7); end
      P_ABORT: abort = 1'b1;
      P_WRITE: begin wr_en = 1'b1; wr_recipe = RID_W'(2); wr_ch = CH_W'(2); wr_ratio = RATIO_W'(5); end
      P_RST:   rst = 1'b1;
      default: ;
    endcase
  endtask

  task automatic clear_pokes();
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; rst = 1'b0;
  endtask

  task automatic push_seg(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Recipe 2 = {2,0,1,3}
  task automatic push_recipe2();
    push_seg(V0, 6); push_seg(MT, 2); push_seg(MT, 2); push_seg(V2, 3);
    push_seg(MT, 2); push_seg(V3, 9); push_seg(DN, 1); push_seg(ID, 1);
  endtask

  task automatic push_zeros();
    push_seg(MT, 6); push_seg(DN, 1); push_seg(ID, 1);
  endtask

  // Scoreboard: one comparison per cycle until the expected queue is empty.
  task automatic drain(input string tag, input int poke_at, input int poke_kind, output int busy_cnt);
    int k;
    logic [W-1:0] e;
    k = 0;
    busy_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", tag, k), 32'(obs_vec), 32'(e));
      if (busy) busy_cnt++;
      if (k == poke_at) apply_poke(poke_kind);
      if (k == poke_at + 1) clear_pokes();
      k++;
    end
    clear_pokes();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    recipe_id = '0; wr_recipe = '0; wr_ch = '0; wr_ratio = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", 32'(obs_vec), 32'(ID));
    check_eq("reset_cur_recipe", 32'(cur_recipe), 32'd0);
    check_eq("reset_state", 32'(state_dbg), 32'(ST_IDLE));

    tbl_wr(2, 0, 2); tbl_wr(2, 1, 0); tbl_wr(2, 2, 1); tbl_wr(2, 3, 3);
    tbl_wr(5, 0, 1); tbl_wr(5, 1, 2);

    push_recipe2(); start_pour(2);
    drain("pour2", -10, P_NONE, bc);
    check_eq("pour2_busy_cycles", 32'(bc), 32'd24);
    check_eq("pour2_cur_recipe", 32'(cur_recipe), 32'd2);

    push_recipe2(); start_pour(2);
    drain("start_ignored", 3, P_START, bc);
    check_eq("start_ignored_busy", 32'(bc), 32'd24);
    check_eq("start_ignored_cur_recipe", 32'(cur_recipe), 32'd2);

    push_recipe2(); start_pour(2);
    drain("wr_busy", 4, P_WRITE, bc);
    push_recipe2(); start_pour(2);
    drain("readback", -10, P_NONE, bc);
    check_eq("readback_busy", 32'(bc), 32'd24);

    // Recipe 5 = {1,2,0,0}; abort on the 2nd valve1 cycle
    push_seg(V0, 3); push_seg(MT, 2); push_seg(V1, 2); push_seg(DA, 1); push_seg(ID, 1);
    start_pour(5);
    drain("abort", 6, P_ABORT, bc);
    check_eq("abort_busy", 32'(bc), 32'd7);
    check_eq("abort_cur_recipe", 32'(cur_recipe), 32'd5);

    // Write and start in the same IDLE cycle: pour uses the all-zero pre-write recipe 6
    wr_en = 1'b1; wr_recipe = RID_W'(6); wr_ch = '0; wr_ratio = RATIO_W'(4);
    start = 1'b1; recipe_id = RID_W'(6);
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    push_zeros();
    drain("zero6", -10, P_NONE, bc);
    check_eq("zero6_busy", 32'(bc), 32'd6);
    push_seg(V0, 12); push_seg(MT, 6); push_seg(DN, 1); push_seg(ID, 1);
    start_pour(6);
    drain("post_wr6", -10, P_NONE, bc);

    // Reset during the first carousel advance of recipe 2
    push_seg(V0, 6); push_seg(MT, 1); push_seg(ID, 2);
    start_pour(2);
    drain("rst_mid", 6, P_RST, bc);
    check_eq("rst_cur_recipe", 32'(cur_recipe), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    push_zeros(); start_pour(2);
    drain("cleared2", -10, P_NONE, bc);
    check_eq("cleared2_busy", 32'(bc), 32'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
